// File: rtl/clock_pkg.sv
// Shared widths, alarm state encoding and event-priority indices for the
// timekeeping controller and its alarm state machine.
package clock_pkg;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 4;

  typedef enum logic [1:0] {
    AL_OFF     = 2'd0,
    AL_ARMED   = 2'd1,
    AL_RINGING = 2'd2
  } al_state_e;

  // Lower index wins arbitration.
  localparam int EV_TICK = 0;
  localparam int EV_SEC  = 1;
  localparam int EV_MIN  = 2;
  localparam int EV_HRS  = 3;
  localparam int EV_AL   = 4;
  localparam int EV_TOG  = 5;
  localparam int EV_NUM  = 6;

  // 7-bit increment, compared before the caller truncates to field width.
  function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] last);
    logic [6:0] s;
    s = v + 7'd1;
    if (s > last) begin
      inc_wrap = 7'd0;
    end else begin
      inc_wrap = s;
    end
  endfunction
endpackage

// File: rtl/clock_alarm_fsm.sv
// Alarm state machine: OFF/ARMED/RINGING, ring-duration counter and the
// registered buzzer gate that follows the seconds parity while ringing.
module clock_alarm_fsm
  import clock_pkg::*;
#(
  parameter int RING_SECONDS = 60
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick_srv,
  input  logic toggle_srv,
  input  logic time_match,
  input  logic sec_lsb_next,
  output logic al_on,
  output logic buzzer_gate
);
  localparam int CW = $clog2(RING_SECONDS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RING_SECONDS - 1);

  al_state_e     state_q, state_d;
  logic [CW-1:0] ring_cnt_q, ring_cnt_d;
  logic          al_on_q, al_on_d;
  logic          buzzer_q, buzzer_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= AL_OFF;
      ring_cnt_q <= '0;
      al_on_q    <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      al_on_q    <= al_on_d;
      buzzer_q   <= buzzer_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    case (state_q)
      AL_OFF: begin
        if (toggle_srv) state_d = AL_ARMED;
        else            state_d = AL_OFF;
      end
      AL_ARMED: begin
        if (toggle_srv) begin
          state_d = AL_OFF;
        end else if (tick_srv && time_match) begin
          state_d    = AL_RINGING;
          ring_cnt_d = '0;
        end else begin
          state_d = AL_ARMED;
        end
      end
      AL_RINGING: begin
        if (toggle_srv) begin
          state_d = AL_OFF;
        end else if (tick_srv) begin
          // The tick that enters RINGING is count 0, so this ends after RING_SECONDS ticks.
          if (ring_cnt_q == CNT_LAST) state_d = AL_ARMED;
          else                        ring_cnt_d = ring_cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
          state_d = AL_RINGING;
        end
      end
      default: state_d = AL_OFF;
    endcase
  end

  always_comb begin
    al_on_d  = (state_d != AL_OFF);
    buzzer_d = (state_d == AL_RINGING) && !sec_lsb_next;
  end

  assign al_on       = al_on_q;
  assign buzzer_gate = buzzer_q;
endmodule

// File: rtl/timekeeping_controller.sv
// Captures the 1 Hz tick and button pulses, services one per cycle by fixed
// priority, and maintains time-of-day and alarm-time registers.
module timekeeping_controller
  import clock_pkg::*;
#(
  parameter int HOUR_MAX     = 12,
  parameter int AL_MIN_STEP  = 10,
  parameter int RING_SECONDS = 60
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sec_tick,
  input  logic             sec_adj,
  input  logic             min_adj,
  input  logic             hrs_adj,
  input  logic             al_adj,
  input  logic             al_toggle,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0]  hours,
  output logic [MIN_W-1:0] al_minutes,
  output logic [HR_W-1:0]  al_hours,
  output logic             al_on,
  output logic             buzzer_gate
);
  localparam logic [6:0] MS_LAST = 7'd59;
  localparam logic [6:0] HR_LAST = 7'(HOUR_MAX - 1);
  localparam logic [6:0] AL_STEP = 7'(AL_MIN_STEP);

  logic [EV_NUM-1:0] pending_q, pending_d, req_s, grant_s;
  logic [SEC_W-1:0]  seconds_q, seconds_d;
  logic [MIN_W-1:0]  minutes_q, minutes_d, al_minutes_q, al_minutes_d;
  logic [HR_W-1:0]   hours_q, hours_d, al_hours_q, al_hours_d;
  logic [6:0]        sec_w, min_w, hr_w, al_min_w, al_hr_w, al_sum_s;
  logic              time_match_s;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q    <= '0;
      seconds_q    <= '0;
      minutes_q    <= '0;
      hours_q      <= '0;
      al_minutes_q <= '0;
      al_hours_q   <= '0;
    end else begin
      pending_q    <= pending_d;
      seconds_q    <= seconds_d;
      minutes_q    <= minutes_d;
      hours_q      <= hours_d;
      al_minutes_q <= al_minutes_d;
      al_hours_q   <= al_hours_d;
    end
  end

  always_comb begin
    req_s = {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, sec_tick};
    // Isolate the lowest set bit; a new pulse on the serviced bit re-arms it.
    grant_s   = pending_q & (~pending_q + {{(EV_NUM-1){1'b0}}, 1'b1});
    pending_d = (pending_q & ~grant_s) | req_s;

    sec_w    = {1'b0, seconds_q};
    min_w    = {1'b0, minutes_q};
    hr_w     = {3'd0, hours_q};
    al_min_w = {1'b0, al_minutes_q};
    al_hr_w  = {3'd0, al_hours_q};
    al_sum_s = al_min_w + AL_STEP;

    seconds_d    = seconds_q;
    minutes_d    = minutes_q;
    hours_d      = hours_q;
    al_minutes_d = al_minutes_q;
    al_hours_d   = al_hours_q;

    if (grant_s[EV_TICK]) begin
      seconds_d = SEC_W'(inc_wrap(sec_w, MS_LAST));
      if (sec_w == MS_LAST) begin
        minutes_d = MIN_W'(inc_wrap(min_w, MS_LAST));
        if (min_w == MS_LAST) hours_d = HR_W'(inc_wrap(hr_w, HR_LAST));
        else                  hours_d = hours_q;
      end else begin
        minutes_d = minutes_q;
      end
    end else if (grant_s[EV_SEC]) begin
      seconds_d = SEC_W'(inc_wrap(sec_w, MS_LAST));
    end else if (grant_s[EV_MIN]) begin
      minutes_d = MIN_W'(inc_wrap(min_w, MS_LAST));
    end else if (grant_s[EV_HRS]) begin
      hours_d = HR_W'(inc_wrap(hr_w, HR_LAST));
    end else if (grant_s[EV_AL]) begin
      if (al_sum_s >= 7'd60) begin
        al_minutes_d = MIN_W'(al_sum_s - 7'd60);
        al_hours_d   = HR_W'(inc_wrap(al_hr_w, HR_LAST));
      end else begin
        al_minutes_d = MIN_W'(al_sum_s);
      end
    end else begin
      seconds_d = seconds_q;
    end

    time_match_s = (hours_d == al_hours_q) && (minutes_d == al_minutes_q) &&
                   (seconds_d == 6'd0);
  end

  clock_alarm_fsm #(
    .RING_SECONDS(RING_SECONDS)
  ) u_alarm (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick_srv    (grant_s[EV_TICK]),
    .toggle_srv  (grant_s[EV_TOG]),
    .time_match  (time_match_s),
    .sec_lsb_next(seconds_d[0]),
    .al_on       (al_on),
    .buzzer_gate (buzzer_gate)
  );

  assign seconds    = seconds_q;
  assign minutes    = minutes_q;
  assign hours      = hours_q;
  assign al_minutes = al_minutes_q;
  assign al_hours   = al_hours_q;
endmodule

// File: tb/tb_timekeeping_controller.sv
// Directed test of timekeeping_controller: carries, arbitration order,
// alarm-time stepping, ring/auto-stop/disarm and asynchronous reset.
module tb_timekeeping_controller;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [5:0] req = 6'd0;   // {al_toggle, al_adj, hrs_adj, min_adj, sec_adj, sec_tick}
  logic [5:0] seconds, minutes, al_minutes;
  logic [3:0] hours, al_hours;
  logic       al_on, buzzer_gate;
  int         checks = 0;
  int         errors = 0;

  localparam logic [5:0] TICK = 6'b000001, SEC = 6'b000010, MIN = 6'b000100,
                         HRS  = 6'b001000, AL  = 6'b010000, TOG = 6'b100000;

  timekeeping_controller dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sec_tick   (req[0]),
    .sec_adj    (req[1]),
    .min_adj    (req[2]),
    .hrs_adj    (req[3]),
    .al_adj     (req[4]),
    .al_toggle  (req[5]),
    .seconds    (seconds),
    .minutes    (minutes),
    .hours      (hours),
    .al_minutes (al_minutes),
    .al_hours   (al_hours),
    .al_on      (al_on),
    .buzzer_gate(buzzer_gate)
  );

  always #5 clk = ~clk;

  // One pulse, then let it be captured and serviced; returns at a negedge.
  task automatic pulse(input logic [5:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) req = m;
      @(negedge clk) req = 6'd0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset_n = 1'b0;
    req = 6'd0;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_gate} !== 28'd0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0",
               {seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_gate});
    end
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_tick_wrap();
    pulse(HRS, 11); pulse(MIN, 59); pulse(SEC, 59);
    checks++;
    if ({hours, minutes, seconds} !== {4'd11, 6'd59, 6'd59}) begin
      errors++;
      $display("FAIL set_115959: got %0d:%0d:%0d expected 11:59:59", hours, minutes, seconds);
    end
    @(negedge clk) req = TICK;
    @(negedge clk) req = 6'd0;
    checks++;
    if ({hours, minutes, seconds} !== {4'd11, 6'd59, 6'd59}) begin
      errors++;
      $display("FAIL tick_latency: got %0d:%0d:%0d expected 11:59:59", hours, minutes, seconds);
    end
    @(negedge clk);
    checks++;
    if ({hours, minutes, seconds, al_on} !== {4'd0, 6'd0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL tick_wrap: got %0d:%0d:%0d al_on=%b expected 0:0:0 al_on=0",
               hours, minutes, seconds, al_on);
    end
  endtask

  task automatic test_arbitration();
    pulse(MIN, 10); pulse(SEC, 59);
    @(negedge clk) req = TICK | MIN;
    @(negedge clk) req = 6'd0;
    @(negedge clk);
    checks++;
    if ({hours, minutes, seconds} !== {4'd0, 6'd11, 6'd0}) begin
      errors++;
      $display("FAIL arb_tick_first: got %0d:%0d:%0d expected 0:11:0", hours, minutes, seconds);
    end
    @(negedge clk);
    checks++;
    if ({hours, minutes, seconds} !== {4'd0, 6'd12, 6'd0}) begin
      errors++;
      $display("FAIL arb_min_second: got %0d:%0d:%0d expected 0:12:0", hours, minutes, seconds);
    end
  endtask

  task automatic test_al_adj();
    do_reset();
    pulse(AL, 7);
    checks++;
    if ({al_hours, al_minutes} !== {4'd1, 6'd10}) begin
      errors++;
      $display("FAIL al_adj_x7: got %0d:%0d expected 1:10", al_hours, al_minutes);
    end
    pulse(AL, 64);
    checks++;
    if ({al_hours, al_minutes, al_on} !== {4'd11, 6'd50, 1'b0}) begin
      errors++;
      $display("FAIL al_1150: got %0d:%0d al_on=%b expected 11:50 al_on=0", al_hours, al_minutes, al_on);
    end
    pulse(AL, 1);
    checks++;
    if ({al_hours, al_minutes} !== {4'd0, 6'd0}) begin
      errors++;
      $display("FAIL al_wrap: got %0d:%0d expected 0:0", al_hours, al_minutes);
    end
  endtask

  task automatic test_ring();
    do_reset();
    pulse(AL, 1); pulse(MIN, 9); pulse(SEC, 59); pulse(TOG, 1);
    checks++;
    if ({al_on, buzzer_gate} !== 2'b10) begin
      errors++;
      $display("FAIL armed: got al_on=%b buzz=%b expected 1 0", al_on, buzzer_gate);
    end
    pulse(TICK, 1);
    checks++;
    if ({minutes, seconds, al_on, buzzer_gate} !== {6'd10, 6'd0, 2'b11}) begin
      errors++;
      $display("FAIL ring_start: got %0d:%0d al_on=%b buzz=%b expected 10:0 1 1",
               minutes, seconds, al_on, buzzer_gate);
    end
    pulse(TICK, 1);
    checks++;
    if (buzzer_gate !== 1'b0) begin
      errors++;
      $display("FAIL ring_odd_sec: got buzz=%b expected 0", buzzer_gate);
    end
    pulse(TICK, 57);
    checks++;
    if ({seconds, buzzer_gate} !== {6'd58, 1'b1}) begin
      errors++;
      $display("FAIL ring_at_58: got sec=%0d buzz=%b expected 58 1", seconds, buzzer_gate);
    end
    pulse(TICK, 2);
    checks++;
    if ({minutes, seconds, al_on, buzzer_gate} !== {6'd11, 6'd0, 2'b10}) begin
      errors++;
      $display("FAIL ring_auto_stop: got %0d:%0d al_on=%b buzz=%b expected 11:0 1 0",
               minutes, seconds, al_on, buzzer_gate);
    end
  endtask

  task automatic test_toggle_and_button();
    pulse(SEC, 59); pulse(MIN, 8); pulse(AL, 1); pulse(TICK, 1);
    checks++;
    if ({minutes, seconds, buzzer_gate} !== {6'd20, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL ring2_start: got %0d:%0d buzz=%b expected 20:0 1", minutes, seconds, buzzer_gate);
    end
    @(negedge clk) req = TOG;
    @(negedge clk) req = 6'd0;
    checks++;
    if ({al_on, buzzer_gate} !== 2'b11) begin
      errors++;
      $display("FAIL toggle_latency: got al_on=%b buzz=%b expected 1 1", al_on, buzzer_gate);
    end
    @(negedge clk);
    checks++;
    if ({al_on, buzzer_gate} !== 2'b00) begin
      errors++;
      $display("FAIL toggle_off: got al_on=%b buzz=%b expected 0 0", al_on, buzzer_gate);
    end
    pulse(TOG, 1); pulse(AL, 1); pulse(MIN, 10);
    checks++;
    if ({minutes, seconds, al_minutes, al_on, buzzer_gate} !== {6'd30, 6'd0, 6'd30, 2'b10}) begin
      errors++;
      $display("FAIL button_no_ring: got %0d:%0d al_min=%0d al_on=%b buzz=%b expected 30:0 30 1 0",
               minutes, seconds, al_minutes, al_on, buzzer_gate);
    end
  endtask

  task automatic test_reset_mid_ring();
    pulse(AL, 1); pulse(MIN, 9); pulse(SEC, 59); pulse(TICK, 1);
    checks++;
    if ({minutes, seconds, buzzer_gate} !== {6'd40, 6'd0, 1'b1}) begin
      errors++;
      $display("FAIL ring3_start: got %0d:%0d buzz=%b expected 40:0 1", minutes, seconds, buzzer_gate);
    end
    @(negedge clk) req = SEC;
    @(posedge clk);
    #2 reset_n = 1'b0;
    req = 6'd0;
    #1;
    checks++;
    if ({seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_gate} !== 28'd0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0",
               {seconds, minutes, hours, al_minutes, al_hours, al_on, buzzer_gate});
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({seconds, al_on, buzzer_gate} !== {6'd0, 2'b00}) begin
      errors++;
      $display("FAIL pending_lost: got sec=%0d al_on=%b buzz=%b expected 0 0 0",
               seconds, al_on, buzzer_gate);
    end
  endtask

  initial begin
    test_reset();
    test_tick_wrap();
    test_arbitration();
    test_al_adj();
    test_ring();
    test_toggle_and_button();
    test_reset_mid_ring();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
